// File: rtl/sll_multicycle.sv
// Iterative logical-left shifter: one bit per clock, zero fill, one-cycle done pulse.
// Latency from accepted start to done is shamt+1 cycles; back-to-back starts are taken from DONE.
module sll_multicycle #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] rt,
  input  logic [SHW-1:0]   shamt,
  output logic [WIDTH-1:0] rd,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [SHW-1:0] CNT_ONE = {{(SHW-1){1'b0}}, 1'b1};

  logic [1:0]       state_reg;
  logic [WIDTH-1:0] sreg_reg;
  logic [SHW-1:0]   cnt_reg;
  logic [WIDTH-1:0] rd_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      sreg_reg  <= '0;
      cnt_reg   <= '0;
      rd_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            sreg_reg  <= rt;
            cnt_reg   <= shamt;
            state_reg <= SHIFT;
          end
        end
        SHIFT: begin
          // cnt counts remaining shifts; the zero-count cycle publishes the result
          if (cnt_reg == '0) begin
            rd_reg    <= sreg_reg;
            state_reg <= DONE;
          end else begin
            sreg_reg <= {sreg_reg[WIDTH-2:0], 1'b0};
            cnt_reg  <= cnt_reg - CNT_ONE;
          end
        end
        DONE: begin
          if (start) begin
            sreg_reg  <= rt;
            cnt_reg   <= shamt;
            state_reg <= SHIFT;
          end else begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Status decoded straight from state so reset clears it without a clock edge
  assign busy = (state_reg == SHIFT);
  assign done = (state_reg == DONE);
  assign rd   = rd_reg;

endmodule
